// File: rtl/aes_pkg.sv
// Shared AES-128 constants, counter types and lookup tables for the byte-serial key expander.
package aes_pkg;

  localparam int NB = 16;
  localparam int NR = 10;
  localparam int BYTE_W = 4;
  localparam int ROUND_W = 4;

  typedef logic [BYTE_W-1:0]  byte_cnt_t;
  typedef logic [ROUND_W-1:0] round_cnt_t;

  typedef enum logic {
    ST_RUN,
    ST_DONE
  } state_t;

  // Element 0 sits in the most significant byte of the literal.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] rcon(input round_cnt_t r);
    logic [7:0] rc;
    rc = 8'h00;
    case (r)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box lookup.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] value,
  output logic [7:0] subst
);

  assign subst = SBOX[value];

endmodule

// File: rtl/key_expansion_byte_serial.sv
// Byte-serial AES-128 round-key generator with an AddRoundKey XOR on the MixColumns byte stream.
//
// state   | meaning
// ST_RUN  | emitting one round-key byte per clock, rounds 0..NR
// ST_DONE | all bytes emitted; outputs frozen until reset
module key_expansion_byte_serial #(
  parameter int NR = aes_pkg::NR,
  parameter int NB = aes_pkg::NB
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] input_key,
  input  logic [7:0] input_MixCol,
  output logic [7:0] key_out,
  output logic [7:0] ark_out,
  output logic       out_valid,
  output logic [3:0] round,
  output logic [3:0] byte_idx,
  output logic       done
);
  import aes_pkg::*;

  localparam round_cnt_t LAST_ROUND = round_cnt_t'(NR);
  localparam byte_cnt_t  LAST_BYTE  = byte_cnt_t'(NB - 1);

  state_t     state, state_nxt;
  byte_cnt_t  b;
  round_cnt_t r;
  logic [7:0] key_reg [NB];
  logic [1:0] row;
  logic [1:0] rot_row;
  logic [7:0] sbox_in;
  logic [7:0] sbox_out;
  logic [7:0] w;
  logic       last;

  assign row     = b[1:0];
  assign rot_row = row + 2'd1;
  // The last word (bytes 12..15) is only overwritten in column 3, after column 0
  // has finished reading it, so the in-place key register still holds the old word here.
  assign sbox_in = key_reg[{2'b11, rot_row}];
  assign last    = (r == LAST_ROUND) && (b == LAST_BYTE);

  aes_sbox u_sbox (
    .value (sbox_in),
    .subst (sbox_out)
  );

  always_comb begin
    w = input_key;
    if (r != '0) begin
      if (b[3:2] == 2'b00)
        w = key_reg[b] ^ sbox_out ^ ((row == 2'd0) ? rcon(r) : 8'h00);
      else
        w = key_reg[b] ^ key_reg[b - byte_cnt_t'(4)];
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == ST_RUN && last)
      state_nxt = ST_DONE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= ST_RUN;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      b         <= '0;
      r         <= '0;
      key_out   <= '0;
      ark_out   <= '0;
      round     <= '0;
      byte_idx  <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      for (int i = 0; i < NB; i++)
        key_reg[i] <= '0;
    end else begin
      out_valid <= (state == ST_RUN);
      done      <= (state == ST_DONE);
      if (state == ST_RUN) begin
        key_reg[b] <= w;
        key_out    <= w;
        ark_out    <= input_MixCol ^ w;
        round      <= r;
        byte_idx   <= b;
        b          <= b + byte_cnt_t'(1);
        if (b == LAST_BYTE)
          r <= r + round_cnt_t'(1);
      end
    end
  end

endmodule

// File: tb/tb_key_expansion_byte_serial.sv
// Scoreboard bench for the byte-serial AES-128 key expander against an independent word-wise model.
module tb_key_expansion_byte_serial;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] input_key = '0;
  logic [7:0] input_MixCol = '0;
  logic [7:0] key_out, ark_out;
  logic       out_valid, done;
  logic [3:0] round, byte_idx;

  always #5 clk = ~clk;

  key_expansion_byte_serial dut (
    .clk          (clk),
    .rst          (rst),
    .input_key    (input_key),
    .input_MixCol (input_MixCol),
    .key_out      (key_out),
    .ark_out      (ark_out),
    .out_valid    (out_valid),
    .round        (round),
    .byte_idx     (byte_idx),
    .done         (done)
  );

  typedef struct packed {
    logic [7:0] k;
    logic [7:0] a;
    logic [3:0] r;
    logic [3:0] b;
  } exp_t;

  int         n_vec = 0;
  int         n_err = 0;
  exp_t       sb_q[$];
  logic [7:0] sbt [256];
  logic [7:0] ek [176];
  logic [7:0] cap_key [11][16];
  logic [7:0] cap_ark [16];

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_MIX = 128'h3243f6a8885a308d313198a2e0370734;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p = 8'h00;
    logic [7:0] a = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return 8'((v << n) | (v >> (8 - n)));
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbt[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbt[t[31:24]], sbt[t[23:16]], sbt[t[15:8]], sbt[t[7:0]]} ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 44; i++)
      for (int n = 0; n < 4; n++) ek[4*i+n] = w[i][31-8*n -: 8];
  endtask

  function automatic logic [127:0] cap_row(input int r);
    logic [127:0] v;
    for (int i = 0; i < 16; i++) v[127-8*i -: 8] = cap_key[r][i];
    return v;
  endfunction

  function automatic logic [127:0] cap_ark_row();
    logic [127:0] v;
    for (int i = 0; i < 16; i++) v[127-8*i -: 8] = cap_ark[i];
    return v;
  endfunction

  always @(negedge clk) begin
    if (rst && out_valid) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_empty got r%0d b%0d key %h exp none", round, byte_idx, key_out);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk($sformatf("r%0d_b%0d", e.r, e.b), {key_out, ark_out, round, byte_idx}, e);
      end
      if (round <= 4'd10) cap_key[round][byte_idx] = key_out;
      if (round == 4'd0) cap_ark[byte_idx] = ark_out;
    end
  end

  // stop_at < 0 runs the full schedule; otherwise reset is pulsed in the middle of that cycle's output.
  task automatic run_seq(input logic [127:0] key, input logic [127:0] mix0, input bit zero_mix,
                         input int stop_at);
    logic [15:0] snap;
    expand(key);
    for (int r = 0; r < 11; r++)
      for (int i = 0; i < 16; i++) cap_key[r][i] = 8'hxx;
    for (int i = 0; i < 16; i++) cap_ark[i] = 8'hxx;
    sb_q.delete();
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 176; k++) begin
      int r, b;
      exp_t e;
      if (k > 0) @(negedge clk);
      if (k == 0) chk("valid_pre", 128'(out_valid), 128'd0);
      if (k == 1) chk("valid_rise", 128'(out_valid), 128'd1);
      r = k / 16;
      b = k % 16;
      input_key    = (k < 16) ? key[127-8*b -: 8] : 8'($urandom);
      input_MixCol = (k < 16) ? mix0[127-8*b -: 8] : ((zero_mix || r == 1) ? 8'h00 : 8'($urandom));
      e.k = ek[k];
      e.a = input_MixCol ^ ek[k];
      e.r = 4'(r);
      e.b = 4'(b);
      sb_q.push_back(e);
      if (k == stop_at) begin
        @(posedge clk);
        #2 rst = 1'b0;
        #1 chk("rst_async", 128'({key_out, ark_out, out_valid, round, byte_idx, done}), 128'd0);
        sb_q.delete();
        return;
      end
    end
    @(negedge clk);
    @(negedge clk);
    chk("done_set", 128'({done, out_valid}), 128'b10);
    chk("hold_key", 128'(key_out), 128'(ek[175]));
    chk("sb_drained", 128'(sb_q.size()), 128'd0);
    snap = {key_out, ark_out};
    for (int i = 0; i < 20; i++) begin
      input_key    = 8'($urandom);
      input_MixCol = 8'($urandom);
      @(negedge clk);
      chk($sformatf("stable_%0d", i), 128'({done, out_valid, key_out, ark_out}), 128'({2'b10, snap}));
    end
  endtask

  initial begin
    build_sbox();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      input_key    = 8'($urandom);
      input_MixCol = 8'($urandom);
      @(negedge clk);
      chk("reset_outs", 128'({key_out, ark_out, out_valid, round, byte_idx, done}), 128'd0);
    end

    run_seq(FIPS_KEY, FIPS_MIX, 1'b0, 4 * 16 + 7);

    run_seq(FIPS_KEY, FIPS_MIX, 1'b0, -1);
    chk("fips_r0_key", cap_row(0), FIPS_KEY);
    chk("fips_r0_ark", cap_ark_row(), 128'h193de3bea0f4e22b9ac68d2ae9f84808);
    chk("fips_r1_key", cap_row(1), 128'ha0fafe1788542cb123a339392a6c7605);
    chk("fips_r10_key", cap_row(10), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    rst = 1'b0;
    @(negedge clk);
    chk("reset_again", 128'({out_valid, done, key_out}), 128'd0);
    run_seq(128'd0, 128'd0, 1'b1, -1);
    chk("zero_r1_key", cap_row(1), 128'h62636363626363636263636362636363);
    chk("zero_r10_key", cap_row(10), 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
